ddr_rd_port_arbiter: RTL and testbench
======================================

// Module: ddr_rd_port_arbiter
// PURPOSE
// - Round-robin arbiter sharing the single DDR read-command port (req/len/addr + data/finish return) between
//   NUM_REQ read clients (readback vout buffer ctrl, laser/scan readback paths) in the ddr_clk domain.
// - Exactly one burst outstanding at a time. Returning data beats and finish are steered to the granted client only.
// PARAMETERS
// - TCQ            0.1   sim clock-to-q delay on all register assignments
// - NUM_REQ        2     number of requesters, 2..4
// - ADDR_WIDTH     30    DDR address width
// - MEM_DATA_BITS  256   DDR data beat width
// - TIMEOUT_CYC    4096  watchdog limit in cycles, used only with DDR_RD_ARB_TIMEOUT_EN
// PORTS
// - ddr_clk_i          in   1                    DDR user clock; sole clock of the block
// - ddr_rst_n_i        in   1                    asynchronous, active-low reset
// - cli_req_i          in   NUM_REQ              per-client request level; held until its cli_finish_o
// - cli_len_i          in   NUM_REQ*8            per-client burst length; slice i = [8*i+7:8*i]
// - cli_addr_i         in   NUM_REQ*ADDR_WIDTH   per-client start address; slice i = [ADDR_WIDTH*i +: ADDR_WIDTH]
// - cli_grant_o        out  NUM_REQ              one-hot grant, held for the whole burst
// - cli_data_valid_o   out  NUM_REQ              rd_ddr_data_valid_i gated by grant
// - cli_data_o         out  MEM_DATA_BITS        rd_ddr_data_i broadcast to all clients, unregistered
// - cli_finish_o       out  NUM_REQ              1-cycle end-of-burst pulse to the granted client
// - rd_ddr_req_o       out  1                    1-cycle read command pulse to DDR controller
// - rd_ddr_len_o       out  8                    latched length of granted client
// - rd_ddr_addr_o      out  ADDR_WIDTH           latched address of granted client
// - rd_ddr_data_valid_i in  1                    DDR read beat valid
// - rd_ddr_data_i      in   MEM_DATA_BITS        DDR read beat
// - rd_ddr_finish_i    in   1                    DDR burst complete
// - busy_o             out  1                    high in any state other than IDLE
// - timeout_err_o      out  1                    sticky watchdog error; constant 0 without the macro
// BEHAVIOUR
// - Reset: state=IDLE; grant=0; rr pointer last=NUM_REQ-1; rd_ddr_req_o=0; rd_ddr_len_o=0; rd_ddr_addr_o=0.
//   Also cli_finish_o=0, busy_o=0, timeout_err_o=0. Assertion mid-burst aborts immediately; no finish is emitted.
// - FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
// - IDLE: if |cli_req_i, pick the first requester searching from last+1 cyclically.
//   Register its one-hot grant, len and addr, and update last. Go to ISSUE. Arbitration latency: 1 cycle.
// - ISSUE: rd_ddr_req_o=1 for exactly this one cycle. Go to WAIT.
// - WAIT: cli_data_valid_o[g] = rd_ddr_data_valid_i (0-cycle, combinational); other bits stay 0.
//   On rd_ddr_finish_i: cli_finish_o[g]=1 for the next cycle and go to DONE.
//   A beat coincident with finish is still forwarded.
// - DONE: grant is cleared. One dead cycle so the client can drop cli_req_i before re-arbitration. Go to IDLE.
// - Back-to-back: a client still requesting in IDLE competes normally. Round-robin guarantees no starvation:
//   with all clients requesting, grants rotate 0,1,..,NUM_REQ-1.
// - rd_ddr_finish_i or rd_ddr_data_valid_i in IDLE/ISSUE/DONE: ignored, not forwarded.
// - cli_req_i deasserting while granted: the burst still completes; finish is still pulsed.
// - len/addr changes on cli_* after grant have no effect. rd_ddr_len_o/addr_o stay stable until the next grant.
// - len is passed through untouched; no length arithmetic is done in the block.
// CONFIGURATION
// - DDR_RD_ARB_TIMEOUT_EN defined:
//   - A 16-bit cycle counter runs in WAIT.
//   - When it reaches TIMEOUT_CYC without rd_ddr_finish_i: set timeout_err_o (sticky until reset),
//     pulse cli_finish_o[g] anyway, and go to DONE.
//   - Counter clears on entering WAIT.
// - Macro undefined: no counter; WAIT waits indefinitely; timeout_err_o tied 0.
// TESTING
// - Reset then cli_req_i=2'b01, len=128, addr=0x100:
//   -> grant=01 next cycle; rd_ddr_req_o 1-cycle pulse with len=128, addr=0x100.
// - 128 data beats then finish on that burst -> cli_data_valid_o[0] shows exactly 128 beats;
//   cli_data_valid_o[1] shows none; cli_finish_o=01 for exactly 1 cycle; busy_o low 2 cycles after finish.
// - Both clients request continuously for 4 bursts -> grant order 0,1,0,1.
//   Each rd_ddr_addr_o matches its client's address.
// - Spurious rd_ddr_finish_i and data_valid while in IDLE -> no cli_finish_o, no cli_data_valid_o, state unchanged.
// - ddr_rst_n_i low mid-WAIT after 50 beats -> all outputs return to reset values asynchronously.
//   Next request is granted normally after release.
// - DDR_RD_ARB_TIMEOUT_EN with TIMEOUT_CYC=64 and finish withheld -> timeout_err_o=1 after 64 WAIT cycles;
//   cli_finish_o pulses once; the next client is still served.

Source files
------------

// File: rtl/ddr_rd_port_arbiter_if.sv
// Signal bundle between DDR read clients, the read-port arbiter and the DDR read-command port.
// master: client/DDR-controller side; slave: the arbiter.
interface ddr_rd_port_arbiter_if #(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned ADDR_WIDTH    = 30,
  parameter int unsigned MEM_DATA_BITS = 256
);
  logic [NUM_REQ-1:0]            cli_req;
  logic [NUM_REQ*8-1:0]          cli_len;
  logic [NUM_REQ*ADDR_WIDTH-1:0] cli_addr;
  logic [NUM_REQ-1:0]            cli_grant;
  logic [NUM_REQ-1:0]            cli_data_valid;
  logic [MEM_DATA_BITS-1:0]      cli_data;
  logic [NUM_REQ-1:0]            cli_finish;

  logic                          rd_ddr_req;
  logic [7:0]                    rd_ddr_len;
  logic [ADDR_WIDTH-1:0]         rd_ddr_addr;
  logic                          rd_ddr_data_valid;
  logic [MEM_DATA_BITS-1:0]      rd_ddr_data;
  logic                          rd_ddr_finish;

  modport master (
    output cli_req, cli_len, cli_addr,
    output rd_ddr_data_valid, rd_ddr_data, rd_ddr_finish,
    input  cli_grant, cli_data_valid, cli_data, cli_finish,
    input  rd_ddr_req, rd_ddr_len, rd_ddr_addr
  );

  modport slave (
    input  cli_req, cli_len, cli_addr,
    input  rd_ddr_data_valid, rd_ddr_data, rd_ddr_finish,
    output cli_grant, cli_data_valid, cli_data, cli_finish,
    output rd_ddr_req, rd_ddr_len, rd_ddr_addr
  );
endinterface

// File: rtl/ddr_rd_port_arbiter.sv
// Round-robin arbiter sharing one DDR read-command port among NUM_REQ clients, one burst at a time.
// Optional watchdog on the WAIT state enabled by defining DDR_RD_ARB_TIMEOUT_EN.
module ddr_rd_port_arbiter #(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned ADDR_WIDTH    = 30,
  parameter int unsigned MEM_DATA_BITS = 256
`ifdef DDR_RD_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC   = 4096
`endif
) (
  input  logic                  ddr_clk_i,
  input  logic                  ddr_rst_n_i,
  ddr_rd_port_arbiter_if.slave  bus,
  output logic                  busy_o,
  output logic                  timeout_err_o
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      finish_q, finish_d;
  logic [IdxW-1:0]         last_q, last_d;
  logic [7:0]              len_q, len_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [MEM_DATA_BITS-1:0] data_fwd;

  logic                    pick_found;
  int unsigned             pick_sel;
  int unsigned             cand;
  logic                    timeout_hit;

  // Cyclic search starting just after the most recently granted client.
  always_comb begin
    pick_found = 1'b0;
    pick_sel   = 0;
    cand       = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_q) + k) % NUM_REQ;
      if (!pick_found && bus.cli_req[cand]) begin
        pick_found = 1'b1;
        pick_sel   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    finish_d = '0;
    last_d   = last_q;
    len_d    = len_q;
    addr_d   = addr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = NUM_REQ'(1) << pick_sel;
          len_d   = bus.cli_len[8*pick_sel +: 8];
          addr_d  = bus.cli_addr[ADDR_WIDTH*pick_sel +: ADDR_WIDTH];
          last_d  = IdxW'(pick_sel);
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (bus.rd_ddr_finish || timeout_hit) begin
          finish_d = grant_q;
          grant_d  = '0;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      finish_q <= '0;
      last_q   <= IdxW'(NUM_REQ - 1);
      len_q    <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      finish_q <= finish_d;
      last_q   <= last_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
    end
  end

`ifdef DDR_RD_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt_q;
  logic        timeout_err_q;

  assign timeout_hit = (state_q == StWait) && (wait_cnt_q == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
    if (!ddr_rst_n_i) begin
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == StIssue) begin
        wait_cnt_q <= '0;
      end else if (state_q == StWait) begin
        wait_cnt_q <= wait_cnt_q + 16'd1;
      end
      // A finish arriving on the last allowed cycle is a normal completion.
      if (timeout_hit && !bus.rd_ddr_finish) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err_o = timeout_err_q;
`else
  assign timeout_hit   = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  assign data_fwd           = bus.rd_ddr_data;
  assign bus.cli_data       = data_fwd;
  assign bus.cli_grant      = grant_q;
  assign bus.cli_finish     = finish_q;
  assign bus.cli_data_valid = (state_q == StWait && bus.rd_ddr_data_valid) ? grant_q : '0;
  assign bus.rd_ddr_req     = (state_q == StIssue);
  assign bus.rd_ddr_len     = len_q;
  assign bus.rd_ddr_addr    = addr_q;
  assign busy_o             = (state_q != StIdle);

endmodule

// File: tb/tb_ddr_rd_port_arbiter.sv
// Directed self-checking bench for ddr_rd_port_arbiter (two clients).
// Inputs change on the falling edge; outputs are sampled on the falling edge or #1 after an input change.
module tb_ddr_rd_port_arbiter;

  localparam int unsigned NumReq   = 2;
  localparam int unsigned AddrW    = 30;
  localparam int unsigned DataBits = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic timeout_err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cnt0, cnt1;

  always #5 clk = ~clk;

  ddr_rd_port_arbiter_if #(
    .NUM_REQ       (NumReq),
    .ADDR_WIDTH    (AddrW),
    .MEM_DATA_BITS (DataBits)
  ) bus ();

  ddr_rd_port_arbiter #(
    .NUM_REQ       (NumReq),
    .ADDR_WIDTH    (AddrW),
    .MEM_DATA_BITS (DataBits)
`ifdef DDR_RD_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC   (64)
`endif
  ) dut (
    .ddr_clk_i     (clk),
    .ddr_rst_n_i   (rst_n),
    .bus           (bus),
    .busy_o        (busy),
    .timeout_err_o (timeout_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cli(input int idx, input logic [7:0] len, input logic [AddrW-1:0] addr);
    bus.cli_len[8*idx +: 8]          = len;
    bus.cli_addr[AddrW*idx +: AddrW] = addr;
  endtask

  // Entered on a falling edge in IDLE with requests already set; leaves on the falling edge
  // of the following IDLE cycle.
  task automatic run_burst(input string tag, input logic [1:0] exp_grant,
                           input logic [AddrW-1:0] exp_addr, input logic [7:0] exp_len);
    @(negedge clk);
    check_eq({tag, "_grant"}, bus.cli_grant, exp_grant);
    check_eq({tag, "_req"},   bus.rd_ddr_req, 1'b1);
    check_eq({tag, "_addr"},  bus.rd_ddr_addr, exp_addr);
    check_eq({tag, "_len"},   bus.rd_ddr_len, exp_len);
    @(negedge clk);
    bus.rd_ddr_data_valid = 1'b1;
    bus.rd_ddr_finish     = 1'b1;
    #1;
    check_eq({tag, "_dv"}, bus.cli_data_valid, exp_grant);
    @(negedge clk);
    bus.rd_ddr_data_valid = 1'b0;
    bus.rd_ddr_finish     = 1'b0;
    check_eq({tag, "_fin"}, bus.cli_finish, exp_grant);
    @(negedge clk);
  endtask

  initial begin
    bus.cli_req           = '0;
    bus.cli_len           = '0;
    bus.cli_addr          = '0;
    bus.rd_ddr_data_valid = 1'b0;
    bus.rd_ddr_data       = '0;
    bus.rd_ddr_finish     = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_grant", bus.cli_grant, 2'b00);
    check_eq("rst_req",   bus.rd_ddr_req, 1'b0);
    check_eq("rst_len",   bus.rd_ddr_len, 8'd0);
    check_eq("rst_addr",  bus.rd_ddr_addr, 30'd0);
    check_eq("rst_fin",   bus.cli_finish, 2'b00);
    check_eq("rst_busy",  busy, 1'b0);
    check_eq("rst_tmo",   timeout_err, 1'b0);
    rst_n = 1'b1;

    // Single 128-beat burst from client 0, last beat coincident with finish
    @(negedge clk);
    set_cli(0, 8'd128, 30'h100);
    set_cli(1, 8'd7,   30'h777);
    bus.cli_req = 2'b01;
    @(negedge clk);
    check_eq("b0_grant", bus.cli_grant, 2'b01);
    check_eq("b0_req",   bus.rd_ddr_req, 1'b1);
    check_eq("b0_len",   bus.rd_ddr_len, 8'd128);
    check_eq("b0_addr",  bus.rd_ddr_addr, 30'h100);
    check_eq("b0_busy",  busy, 1'b1);
    set_cli(0, 8'd3, 30'h3ff);  // post-grant changes must not leak
    @(negedge clk);
    check_eq("b0_req_pulse", bus.rd_ddr_req, 1'b0);
    check_eq("b0_len_hold",  bus.rd_ddr_len, 8'd128);
    check_eq("b0_addr_hold", bus.rd_ddr_addr, 30'h100);
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 128; i++) begin
      bus.rd_ddr_data_valid = 1'b1;
      bus.rd_ddr_data       = DataBits'(i + 32'hA000);
      bus.rd_ddr_finish     = (i == 127);
      #1;
      if (bus.cli_data_valid[0]) cnt0++;
      if (bus.cli_data_valid[1]) cnt1++;
      if (i == 5) check_eq("b0_data", bus.cli_data[63:0], 64'hA005);
      @(negedge clk);
    end
    bus.rd_ddr_data_valid = 1'b0;
    bus.rd_ddr_finish     = 1'b0;
    bus.cli_req           = 2'b00;
    check_eq("b0_beats0", cnt0, 128);
    check_eq("b0_beats1", cnt1, 0);
    check_eq("b0_fin",    bus.cli_finish, 2'b01);
    check_eq("b0_done_grant", bus.cli_grant, 2'b00);
    check_eq("b0_done_busy",  busy, 1'b1);
    @(negedge clk);
    check_eq("b0_fin_1cyc", bus.cli_finish, 2'b00);
    check_eq("b0_idle_busy", busy, 1'b0);

    // Spurious DDR activity while idle
    bus.rd_ddr_data_valid = 1'b1;
    bus.rd_ddr_finish     = 1'b1;
    #1;
    check_eq("sp_dv", bus.cli_data_valid, 2'b00);
    @(negedge clk);
    bus.rd_ddr_data_valid = 1'b0;
    bus.rd_ddr_finish     = 1'b0;
    check_eq("sp_fin",  bus.cli_finish, 2'b00);
    check_eq("sp_busy", busy, 1'b0);
    check_eq("sp_req",  bus.rd_ddr_req, 1'b0);

    // Asynchronous reset mid-WAIT after 50 beats; last=0 so client 1 wins
    set_cli(1, 8'd200, 30'h3000);
    bus.cli_req = 2'b10;
    @(negedge clk);
    check_eq("ab_grant", bus.cli_grant, 2'b10);
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      bus.rd_ddr_data_valid = 1'b1;
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ab_grant0", bus.cli_grant, 2'b00);
    check_eq("ab_dv0",    bus.cli_data_valid, 2'b00);
    check_eq("ab_busy0",  busy, 1'b0);
    check_eq("ab_len0",   bus.rd_ddr_len, 8'd0);
    check_eq("ab_addr0",  bus.rd_ddr_addr, 30'd0);
    bus.rd_ddr_data_valid = 1'b0;
    bus.cli_req           = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("ab_fin0", bus.cli_finish, 2'b00);

    // Both clients requesting continuously: pointer restarts at client 0
    set_cli(0, 8'd4, 30'h1000);
    set_cli(1, 8'd8, 30'h2000);
    bus.cli_req = 2'b11;
    run_burst("rr0", 2'b01, 30'h1000, 8'd4);
    run_burst("rr1", 2'b10, 30'h2000, 8'd8);
    run_burst("rr2", 2'b01, 30'h1000, 8'd4);
    run_burst("rr3", 2'b10, 30'h2000, 8'd8);
    bus.cli_req = 2'b00;
    @(negedge clk);

`ifdef DDR_RD_ARB_TIMEOUT_EN
    // Finish withheld: watchdog fires after 64 WAIT cycles
    bus.cli_req = 2'b01;
    @(negedge clk);
    check_eq("to_grant", bus.cli_grant, 2'b01);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (i == 63) begin
        check_eq("to_err_early", timeout_err, 1'b0);
        check_eq("to_wait_busy", busy, 1'b1);
      end
    end
    @(negedge clk);
    check_eq("to_fin", bus.cli_finish, 2'b01);
    check_eq("to_err", timeout_err, 1'b1);
    bus.cli_req = 2'b10;
    @(negedge clk);
    check_eq("to_fin_1cyc", bus.cli_finish, 2'b00);
    run_burst("to_next", 2'b10, 30'h2000, 8'd8);
    check_eq("to_err_sticky", timeout_err, 1'b1);
    bus.cli_req = 2'b00;
`else
    check_eq("no_tmo", timeout_err, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
